fetch_unit: RTL and testbench

Instruction fetch stage of the rv32 pipeline, directly upstream of decode and the hazard manager. Generates the program counter, issues in-order requests to instruction memory over a request/grant + response-valid handshake, and buffers returned words in a small FIFO. Honours `stall` and `pc_sel` from the hazard manager: a stall holds the head instruction, and a redirect flushes the FIFO, discards in-flight responses and restarts at the branch target.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, in-order imem request/grant/rvalid
// handshake, and a small instruction FIFO feeding decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        pc_sel,
    input  logic [31:0] br_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] instr_fetch,
    output logic [31:0] pc_fetch,
    output logic [31:0] pc_4_fetch
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   next_pc;
    logic [31:0]   pc_q       [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [AW-1:0] pcq_rd, pcq_wr;
    logic [AW-1:0] fifo_rd, fifo_wr;
    logic [CW-1:0] fifo_count, outstanding, discard;
    logic [CW:0]   in_use;
    logic          grant, resp, keep, pop;

    // Issue only while buffered plus in-flight words leave room for one more.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req  = rst && !pc_sel && (in_use < (CW+1)'(DEPTH));
    assign imem_addr = next_pc;

    assign grant = imem_req && imem_gnt;
    assign resp  = imem_rvalid && (outstanding != '0);
    assign keep  = resp && (discard == '0) && !pc_sel;
    assign pop   = fetch_valid && !stall && !pc_sel;

    assign fetch_valid = (fifo_count != '0);
    assign instr_fetch = fetch_valid ? fifo_instr[fifo_rd] : NOP_INSTR;
    assign pc_fetch    = fetch_valid ? fifo_pc[fifo_rd] : next_pc;
    assign pc_4_fetch  = pc_fetch + 32'd4;

    always_ff @(posedge clk) begin
        if (grant) begin
            pc_q[pcq_wr] <= next_pc;
        end
        if (keep) begin
            fifo_pc[fifo_wr]    <= pc_q[pcq_rd];
            fifo_instr[fifo_wr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            next_pc     <= RESET_PC;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (grant) begin
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (resp) begin
                pcq_rd <= pcq_rd + AW'(1);
            end
            outstanding <= outstanding + CW'(grant) - CW'(resp);

            // Every word still in flight after a redirect belongs to the old
            // stream; discarded words are always the oldest, so the new count
            // is simply what remains outstanding once this cycle's word lands.
            if (pc_sel) begin
                next_pc    <= br_target;
                fifo_rd    <= '0;
                fifo_wr    <= '0;
                fifo_count <= '0;
                discard    <= outstanding - CW'(resp);
            end else begin
                if (grant) begin
                    next_pc <= next_pc + 32'd4;
                end
                if (resp && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (keep) begin
                    fifo_wr <= fifo_wr + AW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + AW'(1);
                end
                fifo_count <= fifo_count + CW'(keep) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random back-pressure/latency,
// checked against a stream-level model of the fetched program order.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        pc_sel = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        fetch_valid;
    logic [31:0] instr_fetch;
    logic [31:0] pc_fetch;
    logic [31:0] pc_4_fetch;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .pc_sel      (pc_sel),
        .br_target   (br_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .fetch_valid (fetch_valid),
        .instr_fetch (instr_fetch),
        .pc_fetch    (pc_fetch),
        .pc_4_fetch  (pc_4_fetch)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mem_q[$];
    int          cyc = 0;
    int          last_due = -1;
    int          gnt_prob = 100;
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_assert = 0;
    int          n_fail = 0;
    int          retired = 0;
    int          retired_before = 0;
    bit          spurious = 1'b0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_addr = RESET_PC;

    // Odd multiplier makes every address map to a distinct word.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        check_bit({phase, "_req"}, imem_req, 1'b0);
        check_word({phase, "_addr"}, imem_addr, RESET_PC);
        check_bit({phase, "_valid"}, fetch_valid, 1'b0);
        check_word({phase, "_instr"}, instr_fetch, NOP_INSTR);
        check_word({phase, "_pc"}, pc_fetch, RESET_PC);
        check_word({phase, "_pc4"}, pc_4_fetch, RESET_PC + 32'd4);
    endtask

    // One clock cycle: the memory model drives gnt/rvalid, outputs are checked
    // against the expected program stream, then the model advances.
    task automatic apply_stimulus();
        bit   from_q;
        int   lat;
        req_t r;
        imem_gnt = ($urandom_range(99) < gnt_prob);
        from_q = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        if (from_q) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else if (spurious) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
        if (pc_sel) check_bit("no_req_on_redirect", imem_req, 1'b0);
        if (imem_req) check_word("imem_addr", imem_addr, exp_addr);
        if (fetch_valid && !stall && !pc_sel) begin
            check_word("retire_pc", pc_fetch, exp_pc);
            check_word("retire_instr", instr_fetch, mem_word(exp_pc));
            check_word("retire_pc4", pc_4_fetch, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            retired++;
        end
        if (from_q) void'(mem_q.pop_front());
        if (imem_req && imem_gnt) begin
            lat    = $urandom_range(lat_max, lat_min);
            r.addr = imem_addr;
            r.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            last_due = r.due;
            mem_q.push_back(r);
            exp_addr = exp_addr + 32'd4;
        end
        if (pc_sel) begin
            exp_pc   = br_target;
            exp_addr = br_target;
        end
        check_bit("in_flight_bound", mem_q.size() <= DEPTH, 1'b1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        #1;

        // Release with single-cycle memory: first word visible two cycles later.
        check_bit("first_req", imem_req, 1'b1);
        check_word("first_addr", imem_addr, RESET_PC);
        check_bit("c0_valid", fetch_valid, 1'b0);
        apply_stimulus();
        check_bit("c1_valid", fetch_valid, 1'b0);
        apply_stimulus();
        check_bit("c2_valid", fetch_valid, 1'b1);
        check_word("c2_pc", pc_fetch, RESET_PC);

        // Hold head pc 8 under stall; FIFO fills and issue stops.
        for (int k = 0; k < 20; k++) begin
            if (fetch_valid && pc_fetch == 32'h8) break;
            apply_stimulus();
        end
        stall = 1'b1;
        repeat (6) begin
            check_word("stall_pc", pc_fetch, 32'h8);
            check_word("stall_instr", instr_fetch, mem_word(32'h8));
            apply_stimulus();
        end
        check_bit("full_no_req", imem_req, 1'b0);
        check_bit("full_none_in_flight", mem_q.size() == 0, 1'b1);
        stall = 1'b0;
        apply_stimulus();
        check_bit("after_stall_valid", fetch_valid, 1'b1);
        check_word("after_stall_pc", pc_fetch, 32'hC);
        repeat (6) apply_stimulus();

        // Redirect with two requests in flight.
        lat_min = 2;
        lat_max = 2;
        for (int k = 0; k < 30; k++) begin
            if (mem_q.size() == 2) break;
            apply_stimulus();
        end
        check_bit("two_in_flight", mem_q.size() == 2, 1'b1);
        pc_sel = 1'b1;
        br_target = 32'h100;
        apply_stimulus();
        pc_sel = 1'b0;
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 20; k++) begin
            if (fetch_valid) break;
            apply_stimulus();
        end
        check_word("redirect_head_pc", pc_fetch, 32'h100);
        repeat (6) apply_stimulus();

        // Redirect coinciding with an arriving word while stalled.
        for (int k = 0; k < 20; k++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) break;
            apply_stimulus();
        end
        stall = 1'b1;
        pc_sel = 1'b1;
        br_target = 32'h200;
        apply_stimulus();
        pc_sel = 1'b0;
        check_bit("flush_valid", fetch_valid, 1'b0);
        check_word("flush_instr", instr_fetch, NOP_INSTR);
        check_word("flush_pc", pc_fetch, 32'h200);
        check_word("flush_pc4", pc_4_fetch, 32'h204);
        stall = 1'b0;
        repeat (6) apply_stimulus();

        // PC wrap from the top of the address space.
        pc_sel = 1'b1;
        br_target = 32'hFFFF_FFF8;
        apply_stimulus();
        pc_sel = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (fetch_valid && pc_fetch == 32'hFFFF_FFFC) break;
            apply_stimulus();
        end
        check_word("wrap_pc", pc_fetch, 32'hFFFF_FFFC);
        check_word("wrap_pc4", pc_4_fetch, 32'h0000_0000);
        repeat (8) apply_stimulus();
        check_bit("wrap_past_zero", exp_pc < 32'h100, 1'b1);

        // Random grant back-pressure, 1-3 cycle latency, stalls and redirects.
        gnt_prob = 60;
        lat_min = 1;
        lat_max = 3;
        retired_before = retired;
        repeat (3000) begin
            stall = ($urandom_range(99) < 25);
            if ($urandom_range(99) < 3) begin
                pc_sel = 1'b1;
                br_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            end else begin
                pc_sel = 1'b0;
            end
            apply_stimulus();
        end
        stall = 1'b0;
        pc_sel = 1'b0;
        check_bit("random_progress", (retired - retired_before) > 100, 1'b1);

        // Asynchronous reset in the middle of traffic.
        gnt_prob = 100;
        lat_min = 1;
        lat_max = 1;
        repeat (5) apply_stimulus();
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        mem_q.delete();
        exp_pc = RESET_PC;
        exp_addr = RESET_PC;
        last_due = cyc;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // A response with nothing outstanding must be ignored.
        gnt_prob = 0;
        spurious = 1'b1;
        apply_stimulus();
        spurious = 1'b0;
        check_bit("spurious_ignored", fetch_valid, 1'b0);
        gnt_prob = 100;
        for (int k = 0; k < 20; k++) begin
            if (fetch_valid) break;
            apply_stimulus();
        end
        check_word("restart_pc", pc_fetch, RESET_PC);
        repeat (6) apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
